// File: rtl/sr_frame_capture.sv
// sr_frame_capture
// Deserializes a dynamic frame (SEL=1) followed by a static frame (SEL=0) from
// MOSI into shadow shift registers. On the end-of-sequence flag it checks both
// bit counts and compares the captured words to the expected defaults. The
// verdict is reported through done / match_ok / err_len / err_proto.
// Any sequencing violation parks the block in ERR until a new frame starts.

module sr_frame_capture #(
    parameter int                    SIZESRDYN  = 16,
    parameter int                    SIZESRSTAT = 88,
    parameter logic [SIZESRDYN-1:0]  EXP_DIN    = 16'hABC6,
    parameter logic [SIZESRSTAT-1:0] EXP_STAT   = 88'h123456789ABCDEF1234567
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  SEL,
    input  logic                  aux_SEL,
    input  logic                  MOSI,
    input  logic                  flag_signal,
    output logic [SIZESRDYN-1:0]  din_q,
    output logic [SIZESRSTAT-1:0] stat_q,
    output logic                  busy,
    output logic                  done,
    output logic                  match_ok,
    output logic                  err_len,
    output logic                  err_proto
);

    // Counters must hold SIZE+1 so an overlong frame stays distinguishable
    // from an exact one.
    localparam int CW_D = $clog2(SIZESRDYN + 2);
    localparam int CW_S = $clog2(SIZESRSTAT + 2);

    localparam logic [CW_D-1:0] DYN_FULL  = CW_D'(SIZESRDYN);
    localparam logic [CW_D-1:0] DYN_SAT   = CW_D'(SIZESRDYN + 1);
    localparam logic [CW_D-1:0] DYN_ONE   = CW_D'(1);
    localparam logic [CW_S-1:0] STAT_FULL = CW_S'(SIZESRSTAT);
    localparam logic [CW_S-1:0] STAT_SAT  = CW_S'(SIZESRSTAT + 1);
    localparam logic [CW_S-1:0] STAT_ONE  = CW_S'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DYN   = 3'd1,
        S_STAT  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t                  r_state;
    logic [SIZESRDYN-1:0]    r_sr_din;
    logic [SIZESRSTAT-1:0]   r_sr_stat;
    logic [CW_D-1:0]         r_cnt_din;
    logic [CW_S-1:0]         r_cnt_stat;
    logic [SIZESRDYN-1:0]    r_din_q;
    logic [SIZESRSTAT-1:0]   r_stat_q;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_match_ok;
    logic                    r_err_len;
    logic                    r_err_proto;

    logic                    w_start;
    logic                    w_dyn_bit;
    logic                    w_stat_bit;
    logic                    w_din_room;
    logic                    w_stat_room;
    logic [SIZESRDYN-1:0]    w_din_shift;
    logic [SIZESRSTAT-1:0]   w_stat_shift;
    logic [CW_D-1:0]         w_cnt_din_inc;
    logic [CW_S-1:0]         w_cnt_stat_inc;
    logic                    w_err_len_next;
    logic                    w_data_eq;

    // Bit-qualifier decode and shift/count next values
    assign w_start        = aux_SEL & SEL;
    assign w_dyn_bit      = aux_SEL & SEL;
    assign w_stat_bit     = aux_SEL & ~SEL;
    // Bits beyond the frame size are counted but not shifted in.
    assign w_din_room     = (r_cnt_din  < DYN_FULL);
    assign w_stat_room    = (r_cnt_stat < STAT_FULL);
    assign w_din_shift    = {r_sr_din[SIZESRDYN-2:0], MOSI};
    assign w_stat_shift   = {r_sr_stat[SIZESRSTAT-2:0], MOSI};
    assign w_cnt_din_inc  = (r_cnt_din  == DYN_SAT)  ? r_cnt_din  : r_cnt_din  + DYN_ONE;
    assign w_cnt_stat_inc = (r_cnt_stat == STAT_SAT) ? r_cnt_stat : r_cnt_stat + STAT_ONE;
    assign w_err_len_next = (r_cnt_din != DYN_FULL) | (r_cnt_stat != STAT_FULL);
    assign w_data_eq      = (r_sr_din == EXP_DIN) & (r_sr_stat == EXP_STAT);

    // Frame sequencer: owns shift registers, counters, shadows and status flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_sr_din    <= '0;
            r_sr_stat   <= '0;
            r_cnt_din   <= '0;
            r_cnt_stat  <= '0;
            r_din_q     <= '0;
            r_stat_q    <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_match_ok  <= 1'b0;
            r_err_len   <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            case (r_state)
                // Waiting states: DONE/ERR raise done one cycle after entry and
                // hold results; a dynamic bit starts a fresh frame from any of them.
                S_IDLE, S_DONE, S_ERR: begin
                    if (r_state != S_IDLE) begin
                        r_done <= 1'b1;
                    end
                    if (w_start) begin
                        r_state     <= S_DYN;
                        r_busy      <= 1'b1;
                        r_sr_din    <= {{(SIZESRDYN-1){1'b0}}, MOSI};
                        r_sr_stat   <= '0;
                        r_cnt_din   <= DYN_ONE;
                        r_cnt_stat  <= '0;
                        r_done      <= 1'b0;
                        r_match_ok  <= 1'b0;
                        r_err_len   <= 1'b0;
                        r_err_proto <= 1'b0;
                    end else if ((r_state == S_IDLE) && aux_SEL) begin
                        // Static bit with no preceding dynamic frame.
                        r_state     <= S_ERR;
                        r_err_proto <= 1'b1;
                    end
                end

                S_DYN: begin
                    if (w_dyn_bit) begin
                        if (w_din_room) begin
                            r_sr_din <= w_din_shift;
                        end
                        r_cnt_din <= w_cnt_din_inc;
                    end else if (w_stat_bit) begin
                        // First static bit; the static shadow was cleared at start.
                        r_state    <= S_STAT;
                        r_sr_stat  <= w_stat_shift;
                        r_cnt_stat <= STAT_ONE;
                    end else begin
                        // Dynamic frame cut short by aux_SEL dropping.
                        r_state     <= S_ERR;
                        r_busy      <= 1'b0;
                        r_match_ok  <= 1'b0;
                        r_err_proto <= 1'b1;
                    end
                end

                S_STAT: begin
                    if (w_stat_bit) begin
                        if (w_stat_room) begin
                            r_sr_stat <= w_stat_shift;
                        end
                        r_cnt_stat <= w_cnt_stat_inc;
                    end else if (flag_signal && !aux_SEL) begin
                        r_state <= S_CHECK;
                    end else begin
                        // Dynamic bit after static, or frame end without flag.
                        r_state     <= S_ERR;
                        r_busy      <= 1'b0;
                        r_match_ok  <= 1'b0;
                        r_err_proto <= 1'b1;
                    end
                end

                // Single evaluation cycle: publish shadows and the verdict.
                S_CHECK: begin
                    r_state    <= S_DONE;
                    r_busy     <= 1'b0;
                    r_din_q    <= r_sr_din;
                    r_stat_q   <= r_sr_stat;
                    r_err_len  <= w_err_len_next;
                    r_match_ok <= ~w_err_len_next & w_data_eq;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign din_q     = r_din_q;
    assign stat_q    = r_stat_q;
    assign busy      = r_busy;
    assign done      = r_done;
    assign match_ok  = r_match_ok;
    assign err_len   = r_err_len;
    assign err_proto = r_err_proto;

endmodule

// File: tb/tb_sr_frame_capture.sv
// tb_sr_frame_capture
// Scenario tasks drive serial frames and compare the capture block's outputs
// with a frame-level reference model built from the bit lists that were sent.

module tb_sr_frame_capture;

    localparam logic [15:0] EXP_DIN  = 16'hABC6;
    localparam logic [87:0] EXP_STAT = 88'h123456789ABCDEF1234567;

    logic        CLK;
    logic        RST_N;
    logic        SEL;
    logic        aux_SEL;
    logic        MOSI;
    logic        flag_signal;
    logic [15:0] din_q;
    logic [87:0] stat_q;
    logic        busy;
    logic        done;
    logic        match_ok;
    logic        err_len;
    logic        err_proto;

    int n_cmp  = 0;
    int n_fail = 0;

    bit dq[$];
    bit sq[$];

    sr_frame_capture dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .SEL         (SEL),
        .aux_SEL     (aux_SEL),
        .MOSI        (MOSI),
        .flag_signal (flag_signal),
        .din_q       (din_q),
        .stat_q      (stat_q),
        .busy        (busy),
        .done        (done),
        .match_ok    (match_ok),
        .err_len     (err_len),
        .err_proto   (err_proto)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Inputs change on the falling edge, away from the sampling edge.
    task automatic drive(input logic a, input logic s, input logic m, input logic f);
        @(negedge CLK);
        aux_SEL = a; SEL = s; MOSI = m; flag_signal = f;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        aux_SEL = 0; SEL = 0; MOSI = 0; flag_signal = 0;
        RST_N = 0;
        @(negedge CLK);
        RST_N = 1;
    endtask

    // First nd bits of dw (MSB first), then random filler for overlong frames.
    task automatic load(input logic [15:0] dw, input int nd, input logic [87:0] sw, input int ns);
        dq.delete(); sq.delete();
        for (int i = 0; i < nd; i++) dq.push_back(i < 16 ? dw[15-i] : 1'($urandom_range(0, 1)));
        for (int i = 0; i < ns; i++) sq.push_back(i < 88 ? sw[87-i] : 1'($urandom_range(0, 1)));
    endtask

    // Whole frame, then flag, then idle. flag_at raises flag alongside that bit.
    task automatic send_frame(input int flag_at);
        foreach (dq[i]) drive(1, 1, dq[i], flag_at == i);
        foreach (sq[j]) drive(1, 0, sq[j], flag_at == (dq.size() + j));
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while (done !== 1'b1 && t < 12) begin
            @(negedge CLK);
            t++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: done=%b expected 1", nm, done);
        end
    endtask

    // Reference: words hold the first SIZE bits sent, MSB first and
    // right-aligned; a length error vetoes a match.
    task automatic model(output logic [15:0] ed, output logic [87:0] es, output logic [3:0] ef);
        int kd, ks;
        logic el, em;
        kd = (dq.size() > 16) ? 16 : dq.size();
        ks = (sq.size() > 88) ? 88 : sq.size();
        ed = '0; es = '0;
        for (int i = 0; i < kd; i++) ed[kd-1-i] = dq[i];
        for (int i = 0; i < ks; i++) es[ks-1-i] = sq[i];
        el = (dq.size() != 16) || (sq.size() != 88);
        em = !el && (ed == EXP_DIN) && (es == EXP_STAT);
        ef = {1'b1, em, el, 1'b0};
    endtask

    task automatic test_reset();
        RST_N = 0; aux_SEL = 0; SEL = 0; MOSI = 0; flag_signal = 0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({busy, done, match_ok, err_len, err_proto, din_q, stat_q} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: flags=%b din_q=%h stat_q=%h expected all 0",
                     {busy, done, match_ok, err_len, err_proto}, din_q, stat_q);
        end
        @(negedge CLK);
        RST_N = 1;
    endtask

    task automatic test_nominal();
        load(EXP_DIN, 16, EXP_STAT, 88);
        foreach (dq[i]) begin
            drive(1, 1, dq[i], 0);
            if (i == 1) begin
                n_cmp++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL nominal_busy_dyn: busy=%b expected 1", busy);
                end
            end
        end
        foreach (sq[j]) drive(1, 0, sq[j], 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        n_cmp++;
        if ({busy, done} !== 2'b10) begin
            n_fail++;
            $display("FAIL nominal_check_cycle: busy,done=%b expected 10", {busy, done});
        end
        @(negedge CLK);
        n_cmp++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL nominal_latency_early: done=%b expected 0", done);
        end
        @(negedge CLK);
        n_cmp++;
        if ({done, match_ok, err_len, err_proto} !== 4'b1100) begin
            n_fail++;
            $display("FAIL nominal_flags: got %b expected 1100", {done, match_ok, err_len, err_proto});
        end
        n_cmp++;
        if (din_q !== EXP_DIN || stat_q !== EXP_STAT) begin
            n_fail++;
            $display("FAIL nominal_data: din_q=%h stat_q=%h expected %h %h", din_q, stat_q, EXP_DIN, EXP_STAT);
        end
    endtask

    task automatic test_data_flip();
        logic [87:0] sw;
        sw = EXP_STAT ^ (88'd1 << 40);
        load(EXP_DIN, 16, sw, 88);
        send_frame(-1);
        wait_done("flip");
        n_cmp++;
        if ({done, match_ok, err_len, err_proto} !== 4'b1000) begin
            n_fail++;
            $display("FAIL flip_flags: got %b expected 1000", {done, match_ok, err_len, err_proto});
        end
        n_cmp++;
        if (stat_q !== sw) begin
            n_fail++;
            $display("FAIL flip_stat_q: got %h expected %h", stat_q, sw);
        end
    endtask

    task automatic test_length();
        logic [15:0] ed; logic [87:0] es; logic [3:0] ef;
        int nds[2] = '{15, 16};
        int nss[2] = '{88, 90};
        for (int k = 0; k < 2; k++) begin
            load(EXP_DIN, nds[k], EXP_STAT, nss[k]);
            send_frame(-1);
            wait_done("length");
            model(ed, es, ef);
            n_cmp++;
            if ({done, match_ok, err_len, err_proto} !== 4'b1010) begin
                n_fail++;
                $display("FAIL length_flags[%0d]: got %b expected 1010", k, {done, match_ok, err_len, err_proto});
            end
            n_cmp++;
            if (din_q !== ed || stat_q !== es) begin
                n_fail++;
                $display("FAIL length_data[%0d]: din_q=%h stat_q=%h expected %h %h", k, din_q, stat_q, ed, es);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] ed; logic [87:0] es; logic [3:0] ef;
        logic [15:0] dw; logic [87:0] sw; logic [95:0] t;
        int nd, ns, fa;
        for (int it = 0; it < 16; it++) begin
            nd = ($urandom_range(0, 2) != 0) ? 16 : 15 + 2 * $urandom_range(0, 1);
            ns = ($urandom_range(0, 2) != 0) ? 88 : $urandom_range(86, 90);
            if ($urandom_range(0, 1) != 0) begin
                dw = EXP_DIN; sw = EXP_STAT;
            end else begin
                t  = {$urandom(), $urandom(), $urandom()};
                dw = 16'($urandom());
                sw = t[87:0];
            end
            load(dw, nd, sw, ns);
            fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nd + ns - 1) : -1;
            send_frame(fa);
            wait_done("random");
            model(ed, es, ef);
            n_cmp++;
            if ({done, match_ok, err_len, err_proto} !== ef) begin
                n_fail++;
                $display("FAIL random_flags[%0d]: got %b expected %b (nd=%0d ns=%0d)",
                         it, {done, match_ok, err_len, err_proto}, ef, nd, ns);
            end
            n_cmp++;
            if (din_q !== ed) begin
                n_fail++;
                $display("FAIL random_din[%0d]: got %h expected %h", it, din_q, ed);
            end
            n_cmp++;
            if (stat_q !== es) begin
                n_fail++;
                $display("FAIL random_stat[%0d]: got %h expected %h", it, stat_q, es);
            end
        end
    endtask

    task automatic test_protocol();
        do_reset();
        // Static bit straight from IDLE.
        drive(1, 0, 1, 0);
        drive(0, 0, 0, 0);
        wait_done("proto_idle");
        n_cmp++;
        if ({busy, done, match_ok, err_len, err_proto} !== 5'b01001) begin
            n_fail++;
            $display("FAIL proto_idle: got %b expected 01001", {busy, done, match_ok, err_len, err_proto});
        end
        // Restart from ERR, then drop aux_SEL mid dynamic frame.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, i[0], 0);
            if (i == 1) begin
                n_cmp++;
                if ({busy, done, err_proto} !== 3'b100) begin
                    n_fail++;
                    $display("FAIL proto_restart_clear: busy,done,err_proto=%b expected 100", {busy, done, err_proto});
                end
            end
        end
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        wait_done("proto_dyn");
        n_cmp++;
        if ({done, match_ok, err_len, err_proto} !== 4'b1001) begin
            n_fail++;
            $display("FAIL proto_dyn_drop: got %b expected 1001", {done, match_ok, err_len, err_proto});
        end
        // Dynamic bit in the middle of the static frame.
        load(EXP_DIN, 16, EXP_STAT, 10);
        foreach (dq[i]) drive(1, 1, dq[i], 0);
        foreach (sq[j]) drive(1, 0, sq[j], 0);
        drive(1, 1, 0, 0);
        drive(0, 0, 0, 0);
        wait_done("proto_stat_sel");
        n_cmp++;
        if ({done, match_ok, err_len, err_proto} !== 4'b1001) begin
            n_fail++;
            $display("FAIL proto_stat_sel: got %b expected 1001", {done, match_ok, err_len, err_proto});
        end
        // Complete frame that ends without the flag.
        load(EXP_DIN, 16, EXP_STAT, 88);
        foreach (dq[i]) drive(1, 1, dq[i], 0);
        foreach (sq[j]) drive(1, 0, sq[j], 0);
        drive(0, 0, 0, 0);
        wait_done("proto_noflag");
        n_cmp++;
        if ({done, match_ok, err_len, err_proto} !== 4'b1001) begin
            n_fail++;
            $display("FAIL proto_noflag: got %b expected 1001", {done, match_ok, err_len, err_proto});
        end
    endtask

    task automatic test_reset_mid();
        load(EXP_DIN, 16, EXP_STAT, 88);
        send_frame(-1);
        wait_done("pre_reset");
        foreach (dq[i]) drive(1, 1, dq[i], 0);
        for (int j = 0; j < 50; j++) drive(1, 0, sq[j], 0);
        #2 RST_N = 0;
        #1;
        n_cmp++;
        if ({busy, done, match_ok, err_len, err_proto, din_q, stat_q} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: flags=%b din_q=%h stat_q=%h expected all 0",
                     {busy, done, match_ok, err_len, err_proto}, din_q, stat_q);
        end
        @(negedge CLK);
        aux_SEL = 0; SEL = 0; flag_signal = 0;
        RST_N = 1;
        send_frame(-1);
        wait_done("post_reset");
        n_cmp++;
        if ({done, match_ok, err_len, err_proto} !== 4'b1100 || din_q !== EXP_DIN || stat_q !== EXP_STAT) begin
            n_fail++;
            $display("FAIL post_reset_frame: flags=%b din_q=%h stat_q=%h expected 1100 %h %h",
                     {done, match_ok, err_len, err_proto}, din_q, stat_q, EXP_DIN, EXP_STAT);
        end
    endtask

    task automatic test_back_to_back();
        load(EXP_DIN, 16, EXP_STAT, 88);
        send_frame(-1);
        wait_done("b2b_first");
        n_cmp++;
        if ({done, match_ok, err_len, err_proto} !== 4'b1100) begin
            n_fail++;
            $display("FAIL b2b_first: got %b expected 1100", {done, match_ok, err_len, err_proto});
        end
        foreach (dq[i]) begin
            drive(1, 1, dq[i], 0);
            if (i == 1) begin
                n_cmp++;
                if ({busy, done, match_ok, err_len, err_proto} !== 5'b10000) begin
                    n_fail++;
                    $display("FAIL b2b_restart_clear: got %b expected 10000", {busy, done, match_ok, err_len, err_proto});
                end
            end
        end
        foreach (sq[j]) drive(1, 0, sq[j], 0);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);
        wait_done("b2b_second");
        n_cmp++;
        if ({done, match_ok, err_len, err_proto} !== 4'b1100 || din_q !== EXP_DIN) begin
            n_fail++;
            $display("FAIL b2b_second: flags=%b din_q=%h expected 1100 %h",
                     {done, match_ok, err_len, err_proto}, din_q, EXP_DIN);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_data_flip();
        test_length();
        test_random();
        test_protocol();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
